// File: rtl/clock_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clock_key_ctrl
// Description : Button front end and RUN/STOP/SET mode control for the MM:SS
//               counter; emits held step/clear requests and a periodic tick.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_key_ctrl #(
    parameter int DEBOUNCE_CYC = 500_000,
    parameter int TICK_DIV     = 50_000_000
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       key_run,
    input  logic       key_set,
    input  logic       key_inc,
    input  logic       key_dec,
    input  logic       key_clr,
    output logic       tick,
    output logic       hold,
    output logic       load,
    output logic       plus,
    output logic       det,
    output logic       clr,
    output logic [1:0] mode
);

    localparam int              c_DW        = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int              c_TW        = $clog2(TICK_DIV);
    localparam logic [c_DW-1:0] c_DB_LAST   = c_DW'(DEBOUNCE_CYC - 1);
    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(TICK_DIV - 1);

    localparam logic [1:0] c_ST_RUN  = 2'b00;
    localparam logic [1:0] c_ST_STOP = 2'b01;
    localparam logic [1:0] c_ST_SET  = 2'b10;

    localparam int c_K_RUN = 0;
    localparam int c_K_SET = 1;
    localparam int c_K_INC = 2;
    localparam int c_K_DEC = 3;
    localparam int c_K_CLR = 4;

    logic [4:0]      w_keys;
    logic [4:0]      r_sync1;
    logic [4:0]      r_sync2;
    logic [4:0]      w_db;
    logic [4:0]      r_db_d;
    logic [4:0]      w_pulse;
    logic [c_TW-1:0] r_tick_cnt;
    logic            w_tick;
    logic [1:0]      r_mode;
    logic [1:0]      w_mode_nxt;
    logic            w_in_set;
    logic            w_leave_set;
    logic            r_hold;
    logic            r_load;
    logic            r_plus;
    logic            r_det;
    logic            r_clr;

    assign w_keys = {key_clr, key_dec, key_inc, key_set, key_run};

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db_d  <= '0;
        end else begin
            r_sync1 <= w_keys;
            r_sync2 <= r_sync1;
            r_db_d  <= w_db;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_debounce
            logic [c_DW-1:0] r_cnt;
            logic            r_lvl;

            // Counter only advances while the synced input disagrees with the
            // accepted level, so any bounce back resets it.
            always_ff @(posedge CLOCK_50 or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                    r_lvl <= 1'b0;
                end else if (r_sync2[gi] == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_LAST) begin
                    r_cnt <= '0;
                    r_lvl <= r_sync2[gi];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_db[gi] = r_lvl;
        end
    endgenerate

    assign w_pulse = w_db & ~r_db_d;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == c_TICK_LAST) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign w_tick = (r_tick_cnt == c_TICK_LAST);

    always_comb begin
        w_mode_nxt = r_mode;
        case (r_mode)
            c_ST_RUN:  if (w_pulse[c_K_RUN]) w_mode_nxt = c_ST_STOP;
            c_ST_STOP: begin
                if (w_pulse[c_K_RUN])      w_mode_nxt = c_ST_RUN;
                else if (w_pulse[c_K_SET]) w_mode_nxt = c_ST_SET;
            end
            c_ST_SET:  if (w_pulse[c_K_SET]) w_mode_nxt = c_ST_STOP;
            default:   w_mode_nxt = c_ST_STOP;
        endcase
    end

    assign w_in_set    = (r_mode == c_ST_SET);
    assign w_leave_set = w_in_set && w_pulse[c_K_SET];

    // New requests take priority over the tick clear so a press landing in
    // the tick cycle is carried to the next tick.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= c_ST_STOP;
            r_hold <= 1'b1;
            r_load <= 1'b0;
            r_plus <= 1'b0;
            r_det  <= 1'b0;
            r_clr  <= 1'b0;
        end else begin
            r_mode <= w_mode_nxt;
            r_hold <= (w_mode_nxt != c_ST_RUN);
            r_load <= (w_mode_nxt == c_ST_SET);

            if (w_leave_set) begin
                r_plus <= 1'b0;
                r_det  <= 1'b0;
            end else if (w_in_set && (w_pulse[c_K_INC] ^ w_pulse[c_K_DEC])) begin
                r_plus <= w_pulse[c_K_INC];
                r_det  <= w_pulse[c_K_DEC];
            end else if (w_tick) begin
                r_plus <= 1'b0;
                r_det  <= 1'b0;
            end

            if (w_pulse[c_K_CLR]) begin
                r_clr <= 1'b1;
            end else if (w_tick) begin
                r_clr <= 1'b0;
            end
        end
    end

    assign tick = w_tick;
    assign hold = r_hold;
    assign load = r_load;
    assign plus = r_plus;
    assign det  = r_det;
    assign clr  = r_clr;
    assign mode = r_mode;

endmodule
`default_nettype wire
